life_array_grid: RTL and testbench
==================================

Name: life_array_grid

Overview:
Parametrised ROWS x COLS Conway Game of Life cell array, successor to the fixed 4x4 array. Holds one bit per cell. Supports random-access cell write, a serial scan chain for bulk load/readback, free-running or single-step evolution, and a generation counter with stability and extinction flags. Sits between the host/scan loader and the display driver; the flat alive vector feeds the display.

Parameters:
ROWS, 8, number of rows (>=3)
COLS, 8, number of columns (>=3)
GEN_W, 16, generation counter width
RW, $clog2(ROWS), row index width (derived; not overridden)
CW, $clog2(COLS), column index width (derived; not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
alive  out  ROWS*COLS  cell state; bit index = row*COLS+col
row  in  RW  write row index
col  in  CW  write column index
val  in  1  value written to cell (row,col)
write_enb  in  1  cell write strobe
run  in  1  evolve one generation every cycle while high
step  in  1  single-cycle pulse: evolve exactly one generation (ignored while run=1)
scan  in  1  shift scan chain one position per cycle while high
scan_write_val  in  1  serial data into chain
scan_write_enb  in  1  1: chain tail loads scan_write_val; 0: chain rotates
scan_read_val  out  1  serial data out = alive[0], combinational
scan_done  out  1  one-cycle pulse after ROWS*COLS consecutive scan cycles
generation  out  GEN_W  generations evolved since reset, wraps to 0
stable  out  1  last evolution produced no change
extinct  out  1  alive == 0, combinational

Behaviour:
- Reset (async): alive=0, generation=0, stable=0, scan_done=0, scan counter=0. Reset mid-scan or mid-run aborts immediately; no partial update survives.
- Per-cycle priority: scan > write_enb > evolve (run, or step with run=0). Only one action per cycle; lower-priority requests that cycle are dropped, not queued.
- Write: alive[row*COLS+col] <= val next edge. row>=ROWS or col>=COLS: write ignored. Clears stable.
- Scan shift, N=ROWS*COLS: cell[i] <= cell[i+1] for i<N-1; cell[N-1] <= scan_write_enb ? scan_write_val : cell[0]. N cycles with scan_write_enb=0 restore the original array. A bit presented at scan cycle k (0-based, counted from scan rising) lands in cell k after N cycles. Any scan cycle clears stable.
- Scan counter: increments on each scan cycle, reset to 0 when scan=0. When it reaches N-1 with scan high, scan_done pulses the following cycle and counter returns to 0 (continuous scan pulses every N cycles).
- Evolve: all cells update simultaneously from current state. Neighbour count 0..8 (4-bit). Live cell survives on 2 or 3; dead cell born on exactly 3; else dead. Off-grid neighbours per WRAP_EN.
- Evolve latency: 1 cycle; alive reflects new generation on the edge after run/step sampled.
- generation increments by 1 per evolve, wraps at 2^GEN_W. stable <= (next == current) on each evolve.
- step held high for several cycles with run=0: one evolve per cycle high (level semantics); host drives 1-cycle pulses.
- extinct and evolve: an empty grid still evolves (generation increments, stable=1).

Optional Feature:
WRAP_EN: defined -> toroidal boundary; row 0 neighbours row ROWS-1, col 0 neighbours col COLS-1. Undefined -> off-grid neighbours read as dead (finite plane). Scan, write and counters identical in both builds.

Test Plan:
- Reset, write (3,2),(3,3),(3,4)=1 with 8x8 -> alive=0x00000000_1C000000; pulse step -> alive=0x00000008_08080000, generation=1, stable=0; step again -> 0x00000000_1C000000, generation=2.
- Edge blinker: cells (0,0),(0,1),(0,2), step -> WRAP_EN: alive=0x02000000_00000202; no WRAP_EN: alive=0x202, second step -> alive=0, extinct=1, generation=2.
- Load 2x2 block (1,1),(1,2),(2,1),(2,2) -> alive=0x00000000_00060600; run 3 cycles -> unchanged, stable=1, generation=3; write (0,0)=1 -> stable=0.
- Scan readback: load 0x00000000_00060600, scan=1 for 64 cycles, scan_write_enb=0 -> scan_read_val=1 at cycles 9,10,17,18 only; scan_done pulses once at cycle 64; alive restored.
- Scan load: reset, scan_write_enb=1, scan_write_val=1 at cycles 0 and 63 only, 64 cycles -> alive=0x80000000_00000001.
- Priority/reset: scan=1, write_enb=1, run=1 same cycle -> only shift occurs, generation unchanged; assert reset at scan cycle 20 -> alive=0, scan_done never pulses; write row=7,col=7 on 6x6 build -> ignored.

Source files
------------

// File: rtl/life_array_grid.sv
// life_array_grid: ROWS x COLS Conway Game of Life cell array.
// One register bit per cell. Supports a random-access cell write, a serial
// scan chain for bulk load and readback, free-running or single-step
// evolution, and a generation counter with stable and extinct flags.
// Build option: define WRAP_EN for a toroidal boundary. When it is left
// undefined, neighbours that fall off the grid read as dead.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   alive                cell state, bit index = row*COLS+col
//   row, col, val        write address and data
//   write_enb            cell write strobe
//   run                  evolve one generation every cycle while high
//   step                 evolve one generation per cycle high (ignored while run=1)
//   scan                 shift the scan chain one position per cycle
//   scan_write_val/enb   serial input; when enb=0 the chain rotates
//   scan_read_val        serial output = alive[0] (combinational)
//   scan_done            one-cycle pulse after ROWS*COLS consecutive scan cycles
//   generation           evolutions since reset; wraps to zero
//   stable               last evolution produced no change
//   extinct              alive == 0 (combinational)
module life_array_grid #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned GEN_W = 16,
    parameter int unsigned RW    = $clog2(ROWS),
    parameter int unsigned CW    = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [ROWS*COLS-1:0] alive,
    input  logic [RW-1:0]        row,
    input  logic [CW-1:0]        col,
    input  logic                 val,
    input  logic                 write_enb,
    input  logic                 run,
    input  logic                 step,
    input  logic                 scan,
    input  logic                 scan_write_val,
    input  logic                 scan_write_enb,
    output logic                 scan_read_val,
    output logic                 scan_done,
    output logic [GEN_W-1:0]     generation,
    output logic                 stable,
    output logic                 extinct
);

    localparam int unsigned N   = ROWS * COLS;
    localparam int unsigned SCW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     alive_q, alive_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             stable_q, stable_d;
    logic             scan_done_q, scan_done_d;
    logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;

    logic [N-1:0]               next_gen_c;
    logic [N-1:0]               wr_sel_c;
    logic [ROWS+1:0][COLS+1:0]  pad_c;
    logic                       scan_tail_c;

    // Grid surrounded by a one-cell halo: wrapped copies or constant dead cells.
    for (genvar pr = 0; pr < ROWS + 2; pr++) begin : g_pad_r
        for (genvar pc = 0; pc < COLS + 2; pc++) begin : g_pad_c
`ifdef WRAP_EN
            localparam int unsigned SR = (pr + ROWS - 1) % ROWS;
            localparam int unsigned SC = (pc + COLS - 1) % COLS;
            assign pad_c[pr][pc] = alive_q[SR*COLS + SC];
`else
            if (pr >= 1 && pr <= ROWS && pc >= 1 && pc <= COLS) begin : g_in
                assign pad_c[pr][pc] = alive_q[(pr-1)*COLS + (pc-1)];
            end else begin : g_halo
                assign pad_c[pr][pc] = 1'b0;
            end
`endif
        end
    end

    // Per-cell neighbour count, life rule and write decode.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [3:0] nbr_c;
            assign nbr_c = 4'(pad_c[r][c])   + 4'(pad_c[r][c+1])   + 4'(pad_c[r][c+2])
                         + 4'(pad_c[r+1][c])                       + 4'(pad_c[r+1][c+2])
                         + 4'(pad_c[r+2][c]) + 4'(pad_c[r+2][c+1]) + 4'(pad_c[r+2][c+2]);
            assign next_gen_c[r*COLS + c] = (nbr_c == 4'd3) ||
                                            (alive_q[r*COLS + c] && (nbr_c == 4'd2));
            // An out-of-range address matches no cell, so the write is dropped.
            assign wr_sel_c[r*COLS + c] = write_enb && (row == RW'(r)) && (col == CW'(c));
        end
    end

    assign scan_tail_c = scan_write_enb ? scan_write_val : alive_q[0];

    // Next state: scan beats write beats evolve; one action per cycle.
    always_comb begin
        alive_d     = alive_q;
        gen_d       = gen_q;
        stable_d    = stable_q;
        scan_cnt_d  = '0;
        scan_done_d = 1'b0;
        if (scan) begin
            alive_d     = {scan_tail_c, alive_q[N-1:1]};
            stable_d    = 1'b0;
            scan_done_d = (scan_cnt_q == SCW'(N - 1));
            scan_cnt_d  = scan_done_d ? '0 : scan_cnt_q + SCW'(1);
        end else if (write_enb) begin
            if (|wr_sel_c) begin
                alive_d  = (alive_q & ~wr_sel_c) | (wr_sel_c & {N{val}});
                stable_d = 1'b0;
            end
        end else if (run || step) begin
            alive_d  = next_gen_c;
            gen_d    = gen_q + GEN_W'(1);
            stable_d = (next_gen_c == alive_q);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive_q     <= '0;
            gen_q       <= '0;
            stable_q    <= 1'b0;
            scan_done_q <= 1'b0;
            scan_cnt_q  <= '0;
        end else begin
            alive_q     <= alive_d;
            gen_q       <= gen_d;
            stable_q    <= stable_d;
            scan_done_q <= scan_done_d;
            scan_cnt_q  <= scan_cnt_d;
        end
    end

    assign alive         = alive_q;
    assign generation    = gen_q;
    assign stable        = stable_q;
    assign scan_done     = scan_done_q;
    assign scan_read_val = alive_q[0];
    assign extinct       = (alive_q == '0);

endmodule

// File: tb/tb_life_array_grid.sv
// Randomised self-checking bench for life_array_grid (8x8 plus a 6x6 instance).
module tb_life_array_grid;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] alive;
    logic [2:0]  row, col;
    logic        val, write_enb, run, step, scan, scan_write_val, scan_write_enb;
    logic        scan_read_val, scan_done, stable, extinct;
    logic [15:0] generation;

    logic [35:0] alive6;
    logic [2:0]  row6, col6;
    logic        val6, we6, srv6, sd6, st6, ex6;
    logic [15:0] gen6;

    always #5 clk = ~clk;

    life_array_grid u_dut (
        .clk(clk), .reset(reset), .alive(alive), .row(row), .col(col), .val(val),
        .write_enb(write_enb), .run(run), .step(step), .scan(scan),
        .scan_write_val(scan_write_val), .scan_write_enb(scan_write_enb),
        .scan_read_val(scan_read_val), .scan_done(scan_done), .generation(generation),
        .stable(stable), .extinct(extinct)
    );

    life_array_grid #(.ROWS(6), .COLS(6)) u_dut6 (
        .clk(clk), .reset(reset), .alive(alive6), .row(row6), .col(col6), .val(val6),
        .write_enb(we6), .run(1'b0), .step(1'b0), .scan(1'b0),
        .scan_write_val(1'b0), .scan_write_enb(1'b0),
        .scan_read_val(srv6), .scan_done(sd6), .generation(gen6),
        .stable(st6), .extinct(ex6)
    );

    // Reference model: 2-D grid of cells plus counters.
    bit          g [ROWS][COLS];
    logic [15:0] mgen;
    bit          mstable;
    bit          mdone;
    int          srun;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mflat();
        logic [63:0] f = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                f[r*COLS + c] = g[r][c];
        return f;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                g[r][c] = 1'b0;
        mgen = '0; mstable = 1'b0; mdone = 1'b0; srun = 0;
    endtask

    task automatic m_evolve();
        bit ng [ROWS][COLS];
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
`ifdef WRAP_EN
                        rr = (rr + ROWS) % ROWS;
                        cc = (cc + COLS) % COLS;
`endif
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                            n += int'(g[rr][cc]);
                    end
                end
                ng[r][c] = (n == 3) || (g[r][c] && n == 2);
            end
        end
        mstable = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (ng[r][c] != g[r][c]) mstable = 1'b0;
                g[r][c] = ng[r][c];
            end
        mgen = mgen + 16'd1;
    endtask

    // Chain order is the flat cell index; cell 0 leaves, cell N-1 takes the new bit.
    task automatic m_scan(input bit enb, input bit v);
        bit t = enb ? v : g[0][0];
        for (int k = 0; k < N - 1; k++)
            g[k / COLS][k % COLS] = g[(k+1) / COLS][(k+1) % COLS];
        g[ROWS-1][COLS-1] = t;
    endtask

    task automatic check_all(input string tag);
        logic [63:0] f = mflat();
        chk({tag, "/alive"},   alive, f);
        chk({tag, "/gen"},     64'(generation), 64'(mgen));
        chk({tag, "/stable"},  64'(stable), 64'(mstable));
        chk({tag, "/done"},    64'(scan_done), 64'(mdone));
        chk({tag, "/extinct"}, 64'(extinct), 64'(f == 64'd0));
        chk({tag, "/sro"},     64'(scan_read_val), 64'(f[0]));
    endtask

    // One clock cycle with the given request set, then model update and checks.
    task automatic cyc(input string tag, input int sc, input int swe, input int swv,
                       input int we, input int r, input int c, input int v,
                       input int rn, input int st);
        bit nd;
        scan = (sc != 0); scan_write_enb = (swe != 0); scan_write_val = (swv != 0);
        write_enb = (we != 0); row = 3'(r); col = 3'(c); val = (v != 0);
        run = (rn != 0); step = (st != 0);
        @(posedge clk); #1;
        nd = 1'b0;
        if (sc != 0) begin
            nd = ((srun % N) == N - 1);
            m_scan(swe != 0, swv != 0);
            mstable = 1'b0;
            srun++;
        end else begin
            srun = 0;
            if (we != 0) begin
                g[r][c] = (v != 0);
                mstable = 1'b0;
            end else if (rn != 0 || st != 0) begin
                m_evolve();
            end
        end
        mdone = nd;
        check_all(tag);
    endtask

    task automatic wr(input int r, input int c, input int v);
        cyc("wr", 0, 0, 0, 1, r, c, v, 0, 0);
    endtask

    task automatic idle_inputs();
        scan = 0; scan_write_enb = 0; scan_write_val = 0; write_enb = 0;
        row = '0; col = '0; val = 0; run = 0; step = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_clear();
        check_all("reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int pulses;
        bit smode;
        row6 = '0; col6 = '0; val6 = 0; we6 = 0;
        do_reset();

        // 6x6 instance: out-of-range addresses must be dropped.
        we6 = 1; val6 = 1; row6 = 3'd7; col6 = 3'd7;
        @(posedge clk); #1; chk("w6_77", 64'(alive6), 64'd0);
        row6 = 3'd6; col6 = 3'd0;
        @(posedge clk); #1; chk("w6_60", 64'(alive6), 64'd0);
        row6 = 3'd0; col6 = 3'd6;
        @(posedge clk); #1; chk("w6_06", 64'(alive6), 64'd0);
        row6 = 3'd5; col6 = 3'd5;
        @(posedge clk); #1; chk("w6_55", 64'(alive6), 64'h8_0000_0000);
        we6 = 0;

        // Centre blinker.
        wr(3, 2, 1); wr(3, 3, 1); wr(3, 4, 1);
        chk("blk_load", alive, 64'h00000000_1C000000);
        cyc("blk1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("blk1_const", alive, 64'h00000008_08080000);
        chk("blk1_gen", 64'(generation), 64'd1);
        chk("blk1_stable", 64'(stable), 64'd0);
        cyc("blk2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("blk2_const", alive, 64'h00000000_1C000000);
        chk("blk2_gen", 64'(generation), 64'd2);

        // Edge blinker.
        do_reset();
        wr(0, 0, 1); wr(0, 1, 1); wr(0, 2, 1);
        cyc("edge1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef WRAP_EN
        chk("edge1_const", alive, 64'h02000000_00000202);
`else
        chk("edge1_const", alive, 64'h202);
        cyc("edge2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("edge2_const", alive, 64'd0);
        chk("edge2_ext", 64'(extinct), 64'd1);
        chk("edge2_gen", 64'(generation), 64'd2);
`endif

        // Still-life block under run.
        do_reset();
        wr(1, 1, 1); wr(1, 2, 1); wr(2, 1, 1); wr(2, 2, 1);
        chk("blkld", alive, 64'h00000000_00060600);
        for (int i = 0; i < 3; i++) cyc("run", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("run_const", alive, 64'h00000000_00060600);
        chk("run_stable", 64'(stable), 64'd1);
        chk("run_gen", 64'(generation), 64'd3);
        wr(0, 0, 1);
        chk("wr_clr_stable", 64'(stable), 64'd0);

        // Scan readback with rotation.
        do_reset();
        wr(1, 1, 1); wr(1, 2, 1); wr(2, 1, 1); wr(2, 2, 1);
        pulses = 0;
        for (int k = 0; k < N; k++) begin
            chk("rb_bit", 64'(scan_read_val), 64'(k == 9 || k == 10 || k == 17 || k == 18));
            cyc("rb", 1, 0, 0, 0, 0, 0, 0, 0, 0);
            if (scan_done) pulses++;
        end
        chk("rb_pulses", 64'(pulses), 64'd1);
        chk("rb_restore", alive, 64'h00000000_00060600);
        cyc("rb_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scan load.
        do_reset();
        for (int k = 0; k < N; k++) cyc("sl", 1, 1, int'(k == 0 || k == N - 1), 0, 0, 0, 0, 0, 0);
        chk("sl_const", alive, 64'h80000000_00000001);

        // Priority: scan beats write and run.
        do_reset();
        wr(1, 1, 1); wr(1, 2, 1); wr(2, 1, 1); wr(2, 2, 1);
        cyc("prio", 1, 0, 0, 1, 0, 0, 1, 1, 0);
        chk("prio_const", alive, 64'h00000000_00030300);
        chk("prio_gen", 64'(generation), 64'd0);

        // Reset in the middle of a scan.
        for (int k = 0; k < 20; k++) cyc("ms", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        chk("ms_async_alive", alive, 64'd0);
        chk("ms_async_done", 64'(scan_done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_clear();
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            cyc("ms_post", 1, 1, int'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0);
            if (scan_done) pulses++;
        end
        chk("ms_nopulse", 64'(pulses), 64'd0);

        // Randomised mix of requests against the model.
        do_reset();
        smode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            int op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) smode = !smode;
            cyc("rnd", int'(smode), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'(op < 4 || $urandom_range(0, 3) == 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                int'((op >= 4 && op <= 6) || $urandom_range(0, 4) == 0), int'(op == 7));
        end

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
